// File: rtl/mpu_pkg.sv
// Shared widths, region descriptor and FSM state type for the memory-protection unit.
package mpu_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned REGIONS   = 4;
    localparam int unsigned MAPS      = 16;
    localparam int unsigned PRIOS     = 8;
    localparam int unsigned STACK_TOP = 1280;
    localparam int unsigned LEN_W     = 14;

    localparam int unsigned SLOTS  = MAPS * REGIONS;
    localparam int unsigned IDX_W  = $clog2(SLOTS);
    localparam int unsigned ID_W   = $clog2(MAPS);
    localparam int unsigned PRIO_W = $clog2(PRIOS);
    localparam int unsigned CFG_W  = ADDR_W + LEN_W + 2;
    localparam int unsigned TOP_W  = ADDR_W + 1;

    // One protection region: [base, base+length] with separate read/write enables.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  length;
        logic              wr_en;
        logic              rd_en;
    } mpu_region_t;

    typedef enum logic {
        LOAD  = 1'b0,
        CHECK = 1'b1
    } mpu_state_e;

    // Map (task id) that owns a flat config slot.
    function automatic logic [ID_W-1:0] slot_map(input logic [IDX_W-1:0] idx);
        return ID_W'(idx / IDX_W'(REGIONS));
    endfunction

    // Flat config slot for a given map and row.
    function automatic logic [IDX_W-1:0] slot_idx(input logic [ID_W-1:0] map, input int row);
        return IDX_W'(map) * IDX_W'(REGIONS) + IDX_W'(row);
    endfunction

endpackage

// File: rtl/mpu_guard_unit_region_match.sv
// Single-row region check: address inside [base, base+length] with the needed permission.
module mpu_region_match
    import mpu_pkg::*;
(
    input  mpu_region_t       region,
    input  logic [ADDR_W-1:0] addr,
    input  logic              store,
    output logic              grant
);

    logic [TOP_W-1:0] top;
    logic             hit;

    // Top is formed one bit wider so a region near the end of memory never wraps to low addresses.
    always_comb begin
        top   = {1'b0, region.base} + TOP_W'(region.length);
        hit   = (addr >= region.base) && ({1'b0, addr} <= top);
        grant = hit && (store ? region.wr_en : region.rd_en);
    end

endmodule

// File: rtl/mpu_guard_unit.sv
// Memory-protection guard between LSU address generation and data memory.
module mpu_guard_unit
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CFG_W-1:0]  cfg_wdata,
    input  logic [ID_W-1:0]   id,
    input  logic [PRIO_W-1:0] prio,
    input  logic [ADDR_W-1:0] sp,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_store,
    output logic              resp_valid,
    output logic              resp_fault,
    output logic              fault_irq,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [ID_W-1:0]   fault_id,
    output logic              fault_store,
    input  logic              fault_clr
);

    mpu_region_t       cfg_mem [SLOTS];
    mpu_region_t       cur_map [REGIONS];
    mpu_state_e        state;
    mpu_state_e        next_state;
    logic [ID_W-1:0]   loaded_id;
    logic [ADDR_W-1:0] ep_vec [PRIOS];
    logic [PRIO_W-1:0] last_prio;

    logic               cfg_hits_id;
    logic               load_en;
    logic               accept;
    logic [REGIONS-1:0] row_grant;
    logic               stack_inside;
    logic               access_fault;
    logic               new_fault;

    // Region configuration store, written one slot at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++) begin
                cfg_mem[s] <= '0;
            end
        end else if (cfg_we) begin
            cfg_mem[cfg_idx] <= mpu_region_t'(cfg_wdata);
        end
    end

    assign cfg_hits_id = cfg_we && (slot_map(cfg_idx) == id);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake: any cycle that is not ready reloads map[id]; a write to that map
    // in the same cycle means the copy may be stale, so a further LOAD cycle follows.
    always_comb begin
        next_state = state;
        acc_ready  = 1'b0;
        load_en    = 1'b0;
        case (state)
            LOAD: begin
                load_en    = 1'b1;
                next_state = cfg_hits_id ? LOAD : CHECK;
            end
            CHECK: begin
                if ((id != loaded_id) || cfg_hits_id) begin
                    load_en    = 1'b1;
                    next_state = cfg_hits_id ? LOAD : CHECK;
                end else begin
                    acc_ready = 1'b1;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    // Working copy of the running task's map.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGIONS; r++) begin
                cur_map[r] <= '0;
            end
            loaded_id <= '0;
        end else if (load_en) begin
            for (int r = 0; r < REGIONS; r++) begin
                cur_map[r] <= cfg_mem[slot_idx(id, r)];
            end
            loaded_id <= id;
        end
    end

    // Entry-pointer capture on each rise in interrupt priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < PRIOS; p++) begin
                ep_vec[p] <= '0;
            end
            last_prio <= '0;
        end else begin
            last_prio <= prio;
            if (prio > last_prio) begin
                ep_vec[prio] <= sp;
            end
        end
    end

    for (genvar r = 0; r < REGIONS; r++) begin : g_row
        mpu_region_match u_match (
            .region (cur_map[r]),
            .addr   (acc_addr),
            .store  (acc_store),
            .grant  (row_grant[r])
        );
    end

    // Access decision: stack window uses the entry pointer as it stood before this cycle.
    always_comb begin
        stack_inside = (acc_addr >= ADDR_W'(STACK_TOP)) && (acc_addr <= ep_vec[prio]);
        access_fault = !(stack_inside || (|row_grant));
        accept       = acc_valid && acc_ready;
        new_fault    = accept && access_fault;
    end

    // Response pipeline and sticky first-fault capture; a new fault outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_fault  <= 1'b0;
            fault_irq   <= 1'b0;
            fault_addr  <= '0;
            fault_id    <= '0;
            fault_store <= 1'b0;
        end else begin
            resp_valid <= accept;
            resp_fault <= new_fault;
            if (new_fault && (!fault_irq || fault_clr)) begin
                fault_irq   <= 1'b1;
                fault_addr  <= acc_addr;
                fault_id    <= loaded_id;
                fault_store <= acc_store;
            end else if (fault_clr) begin
                fault_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mpu_guard_unit.sv
// Self-checking bench for mpu_guard_unit: directed vectors plus a cycle-by-cycle reference model.
module tb_mpu_guard_unit;
    import mpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [CFG_W-1:0]  cfg_wdata;
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] prio;
    logic [ADDR_W-1:0] sp;
    logic              acc_valid;
    logic              acc_ready;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_store;
    logic              resp_valid;
    logic              resp_fault;
    logic              fault_irq;
    logic [ADDR_W-1:0] fault_addr;
    logic [ID_W-1:0]   fault_id;
    logic              fault_store;
    logic              fault_clr;

    mpu_guard_unit dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_wdata   (cfg_wdata),
        .id          (id),
        .prio        (prio),
        .sp          (sp),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_addr    (acc_addr),
        .acc_store   (acc_store),
        .resp_valid  (resp_valid),
        .resp_fault  (resp_fault),
        .fault_irq   (fault_irq),
        .fault_addr  (fault_addr),
        .fault_id    (fault_id),
        .fault_store (fault_store),
        .fault_clr   (fault_clr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (integer view of the rules) ----------------
    int m_base [SLOTS];
    int m_len  [SLOTS];
    bit m_wr   [SLOTS];
    bit m_rd   [SLOTS];
    int m_ep   [PRIOS];
    int m_last_prio = 0;
    bit m_valid     = 0;
    int m_loaded    = 0;
    bit e_rv = 0, e_rf = 0, e_irq = 0, e_fst = 0;
    int e_faddr = 0, e_fid = 0;

    initial begin
        for (int s = 0; s < SLOTS; s++) begin
            m_base[s] = 0; m_len[s] = 0; m_wr[s] = 0; m_rd[s] = 0;
        end
        for (int p = 0; p < PRIOS; p++) m_ep[p] = 0;
    end

    function automatic bit model_fault(int a, bit st, int task_id, int p);
        if (a >= 1280 && a <= m_ep[p]) return 1'b0;
        for (int r = 0; r < REGIONS; r++) begin
            int s = task_id * REGIONS + r;
            if (a >= m_base[s] && a <= m_base[s] + m_len[s] && (st ? m_wr[s] : m_rd[s]))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    // Compare every cycle, then advance the model as the coming clock edge would.
    always @(negedge clk) begin
        bit ready_exp, acc, f, cfg_hit;
        cfg_hit   = cfg_we && (int'(cfg_idx) / REGIONS == int'(id));
        ready_exp = m_valid && (int'(id) == m_loaded) && !cfg_hit;
        chk("acc_ready", 32'(acc_ready), 32'(ready_exp));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        if (e_rv) chk("resp_fault", 32'(resp_fault), 32'(e_rf));
        chk("fault_irq", 32'(fault_irq), 32'(e_irq));
        chk("fault_addr", 32'(fault_addr), 32'(e_faddr));
        chk("fault_id", 32'(fault_id), 32'(e_fid));
        chk("fault_store", 32'(fault_store), 32'(e_fst));

        acc = acc_valid && ready_exp;
        f   = model_fault(int'(acc_addr), acc_store, int'(id), int'(prio));
        if (reset) begin
            e_rv = 0; e_rf = 0; e_irq = 0; e_faddr = 0; e_fid = 0; e_fst = 0;
            for (int p = 0; p < PRIOS; p++) m_ep[p] = 0;
            m_last_prio = 0;
            for (int s = 0; s < SLOTS; s++) begin
                m_base[s] = 0; m_len[s] = 0; m_wr[s] = 0; m_rd[s] = 0;
            end
            m_valid = 0; m_loaded = 0;
        end else begin
            e_rv = acc;
            e_rf = acc && f;
            if (acc && f && (!e_irq || fault_clr)) begin
                e_irq = 1; e_faddr = int'(acc_addr); e_fid = int'(id); e_fst = acc_store;
            end else if (fault_clr) begin
                e_irq = 0;
            end
            if (int'(prio) > m_last_prio) m_ep[prio] = int'(sp);
            m_last_prio = int'(prio);
            if (cfg_we) begin
                m_base[cfg_idx] = int'(cfg_wdata[CFG_W-1 -: ADDR_W]);
                m_len[cfg_idx]  = int'(cfg_wdata[LEN_W+1:2]);
                m_wr[cfg_idx]   = cfg_wdata[1];
                m_rd[cfg_idx]   = cfg_wdata[0];
            end
            if (!ready_exp) begin
                if (cfg_hit) m_valid = 0;
                else begin m_valid = 1; m_loaded = int'(id); end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [15:0] b, input logic [13:0] l,
                             input logic w, input logic r);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_wdata = {b, l, w, r};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_acc(input string nm, input logic [15:0] a, input logic st, input logic exp_f);
        acc_valid = 1'b1; acc_addr = a; acc_store = st;
        tick();
        acc_valid = 1'b0;
        chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_fault"}, 32'(resp_fault), 32'(exp_f));
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    logic [15:0] b2b_addr [4];
    logic        b2b_st   [4];
    logic        b2b_f    [4];

    initial begin
        reset = 1'b1; cfg_we = 0; cfg_idx = '0; cfg_wdata = '0; id = '0; prio = '0; sp = '0;
        acc_valid = 0; acc_addr = '0; acc_store = 0; fault_clr = 0;
        tick(); tick();
        chk("rst_ready", 32'(acc_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault_irq", 32'(fault_irq), 32'd0);
        chk("rst_fault_addr", 32'(fault_addr), 32'd0);
        reset = 1'b0;

        // 1: read-only region at map0
        cfg_write(0, 16'h2000, 14'h00FF, 1'b0, 1'b1);
        tick(); tick();
        chk("t1_ready", 32'(acc_ready), 32'd1);
        do_acc("t1_load_top", 16'h20FF, 1'b0, 1'b0);
        do_acc("t1_store_top", 16'h20FF, 1'b1, 1'b1);
        chk("t1_irq", 32'(fault_irq), 32'd1);
        chk("t1_faddr", 32'(fault_addr), 32'h20FF);
        chk("t1_fstore", 32'(fault_store), 32'd1);
        chk("t1_fid", 32'(fault_id), 32'd0);
        clear_fault();
        chk("t1_clr", 32'(fault_irq), 32'd0);

        // 2: entry pointer on priority rise
        prio = 3'd3; sp = 16'h0600;
        tick();
        chk("t2_model_ep3", 32'(m_ep[3]), 32'h0600);
        do_acc("t2_stack_in", 16'h0500, 1'b1, 1'b0);
        do_acc("t2_above_ep", 16'h0601, 1'b1, 1'b1);
        do_acc("t2_below_top", 16'h04FF, 1'b1, 1'b1);
        prio = 3'd1;
        tick();
        do_acc("t2_drop_prio", 16'h0550, 1'b1, 1'b1);
        prio = 3'd3;
        tick();
        do_acc("t2_back_prio", 16'h0550, 1'b0, 1'b0);
        clear_fault();

        // 3: back-to-back accepts
        b2b_addr[0] = 16'h2000; b2b_st[0] = 1'b0; b2b_f[0] = 1'b0;
        b2b_addr[1] = 16'h2010; b2b_st[1] = 1'b1; b2b_f[1] = 1'b1;
        b2b_addr[2] = 16'h0550; b2b_st[2] = 1'b1; b2b_f[2] = 1'b0;
        b2b_addr[3] = 16'h9000; b2b_st[3] = 1'b0; b2b_f[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_valid = 1'b1; acc_addr = b2b_addr[i]; acc_store = b2b_st[i];
            tick();
            chk($sformatf("t3_valid%0d", i), 32'(resp_valid), 32'd1);
            chk($sformatf("t3_fault%0d", i), 32'(resp_fault), 32'(b2b_f[i]));
        end
        acc_valid = 1'b0;
        tick();
        chk("t3_idle", 32'(resp_valid), 32'd0);
        clear_fault();

        // 4: task switch with request held
        cfg_write(5 * REGIONS, 16'h4000, 14'h0010, 1'b1, 1'b1);
        tick();
        id = 4'd5; acc_valid = 1'b1; acc_addr = 16'h4008; acc_store = 1'b1;
        #1;
        chk("t4_ready_low", 32'(acc_ready), 32'd0);
        tick();
        chk("t4_no_resp", 32'(resp_valid), 32'd0);
        chk("t4_ready_back", 32'(acc_ready), 32'd1);
        tick();
        acc_valid = 1'b0;
        chk("t4_resp", 32'(resp_valid), 32'd1);
        chk("t4_map5", 32'(resp_fault), 32'd0);

        // 5: sticky first fault, clear racing a new fault
        do_acc("t5_f1", 16'h3000, 1'b0, 1'b1);
        do_acc("t5_f2", 16'h3004, 1'b0, 1'b1);
        chk("t5_keep_addr", 32'(fault_addr), 32'h3000);
        chk("t5_fid", 32'(fault_id), 32'd5);
        fault_clr = 1'b1;
        do_acc("t5_f3", 16'h3008, 1'b0, 1'b1);
        fault_clr = 1'b0;
        chk("t5_race_irq", 32'(fault_irq), 32'd1);
        chk("t5_race_addr", 32'(fault_addr), 32'h3008);
        clear_fault();

        // 6: region at top of memory must not wrap
        cfg_write(5 * REGIONS + 1, 16'hFFF0, 14'h3FFF, 1'b0, 1'b1);
        tick(); tick();
        do_acc("t6_wrap", 16'h0005, 1'b0, 1'b1);
        do_acc("t6_top", 16'hFFFF, 1'b0, 1'b0);
        do_acc("t6_store_ro", 16'hFFFF, 1'b1, 1'b1);
        do_acc("t6_below_base", 16'hFFEF, 1'b0, 1'b1);

        // reset during an accepted request drops the response
        tick();
        acc_valid = 1'b1; acc_addr = 16'h4008; acc_store = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; acc_valid = 1'b0;
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        chk("rst_mid_irq", 32'(fault_irq), 32'd0);
        chk("rst_mid_ready", 32'(acc_ready), 32'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
